// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ADD/SUB/AND/OR/XOR and an iterative DATA_W-cycle shift-add MUL.
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        alu_control,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              overflow,
    output logic              illegal
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;

    logic [1:0]        state;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] acc_next;
    logic              accept;

    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic              alu_ill;

    // DONE can hand its result over and take a new operation on the same edge.
    assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
    assign accept   = in_valid & in_ready;
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (alu_control)
            OP_ADD: begin
                alu_res = op_a + op_b;
                alu_ovf = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                alu_ovf = (op_a[DATA_W-1] != op_b[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_MUL: alu_res = '0;
            OP_AND: alu_res = op_a & op_b;
            OP_OR:  alu_res = op_a | op_b;
            OP_XOR: alu_res = op_a ^ op_b;
            default: alu_ill = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            count     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (alu_control == OP_MUL) begin
                            mcand     <= op_a;
                            mplier    <= op_b;
                            acc       <= '0;
                            count     <= '0;
                            out_valid <= 1'b0;
                            state     <= ST_MUL;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            overflow  <= alu_ovf;
                            illegal   <= alu_ill;
                            out_valid <= 1'b1;
                            state     <= ST_DONE;
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + CNT_W'(1);
                    // Last iteration: publish the accumulator including this step's add.
                    if (count == CNT_W'(DATA_W - 1)) begin
                        result    <= acc_next;
                        zero      <= (acc_next == '0);
                        overflow  <= 1'b0;
                        illegal   <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: per-scenario tasks with inline checks
// plus a scoreboard queue compared whenever a result is handed off.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_control = 4'h0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         illegal;

    typedef struct packed {
        logic [W-1:0] result;
        logic         zero;
        logic         overflow;
        logic         illegal;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.DATA_W(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alu_control (alu_control),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .illegal     (illegal)
    );

    function automatic exp_t model(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        logic [63:0] p;
        e = '0;
        case (code)
            4'h0: begin
                e.result   = a + b;
                e.overflow = (a[W-1] == b[W-1]) && (e.result[W-1] != a[W-1]);
            end
            4'h1: begin
                e.result   = a - b;
                e.overflow = (a[W-1] != b[W-1]) && (e.result[W-1] != a[W-1]);
            end
            4'h2: begin
                p        = 64'(a) * 64'(b);
                e.result = p[W-1:0];
            end
            4'h3: e.result = a & b;
            4'h4: e.result = a | b;
            4'h5: e.result = a ^ b;
            default: e.illegal = 1'b1;
        endcase
        e.zero = (e.result == '0);
        return e;
    endfunction

    // Scoreboard monitor: a result is consumed when out_valid & out_ready at the edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: result=%h with no pending operation", result);
            end else begin
                mon_e = sb.pop_front();
                if ({result, zero, overflow, illegal} !== mon_e) begin
                    n_bad++;
                    $display("FAIL sb_result: got res=%h z=%b ovf=%b ill=%b, want res=%h z=%b ovf=%b ill=%b",
                             result, zero, overflow, illegal,
                             mon_e.result, mon_e.zero, mon_e.overflow, mon_e.illegal);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present an operation until accepted; returns at accept edge + 1 with in_valid low.
    task automatic send(input logic [3:0] code, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int waited);
        bit acc;
        acc         = 1'b0;
        waited      = 0;
        alu_control = code;
        op_a        = a;
        op_b        = b;
        in_valid    = 1'b1;
        while (!acc && waited < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) waited++;
        end
        in_valid    = 1'b0;
        // Scramble the operand bus: the unit must have sampled on the accept edge.
        op_a        = $urandom;
        op_b        = $urandom;
        alu_control = 4'($urandom);
        n_cmp++;
        if (!acc) begin
            n_bad++;
            $display("FAIL accept_timeout: code=%h not accepted within %0d cycles", code, waited);
        end else begin
            sb.push_back(model(code, a, b));
        end
    endtask

    task automatic test_reset;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step(3);
        reset = 1'b0;
        sb.delete();
        n_cmp++;
        if ({out_valid, result, zero, overflow, illegal} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got v=%b res=%h z=%b ovf=%b ill=%b, want all 0",
                     out_valid, result, zero, overflow, illegal);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_add;
        int w;
        out_ready = 1'b1;
        send(4'h0, 32'd5, 32'd7, w);
        n_cmp++;
        if ({out_valid, result, zero, overflow} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL add_basic: got v=%b res=%h z=%b ovf=%b, want v=1 res=0000000c z=0 ovf=0",
                     out_valid, result, zero, overflow);
        end
        step(1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL add_valid_drop: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_overflow;
        int w;
        out_ready = 1'b1;
        send(4'h0, 32'h7FFF_FFFF, 32'd1, w);
        n_cmp++;
        if ({result, overflow} !== {32'h8000_0000, 1'b1}) begin
            n_bad++;
            $display("FAIL add_overflow: got res=%h ovf=%b, want res=80000000 ovf=1", result, overflow);
        end
        send(4'h1, 32'd3, 32'd3, w);
        n_cmp++;
        if ({result, zero, overflow} !== {32'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL sub_zero: got res=%h z=%b ovf=%b, want res=0 z=1 ovf=0", result, zero, overflow);
        end
        send(4'h1, 32'h8000_0000, 32'd1, w);
        n_cmp++;
        if ({result, overflow} !== {32'h7FFF_FFFF, 1'b1}) begin
            n_bad++;
            $display("FAIL sub_overflow: got res=%h ovf=%b, want res=7fffffff ovf=1", result, overflow);
        end
        step(1);
    endtask

    task automatic test_mul;
        int w;
        int cycles;
        bit saw_ready;
        out_ready = 1'b1;
        send(4'h2, 32'hFFFF_FFFF, 32'd3, w);
        cycles    = 0;
        saw_ready = 1'b0;
        while (!out_valid && cycles < 100) begin
            if (in_ready) saw_ready = 1'b1;
            step(1);
            cycles++;
        end
        n_cmp++;
        if (cycles != W) begin
            n_bad++;
            $display("FAIL mul_latency: got %0d cycles want %0d", cycles, W);
        end
        n_cmp++;
        if (saw_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL mul_in_ready: got in_ready=1 during MUL, want 0");
        end
        n_cmp++;
        if ({result, overflow} !== {32'hFFFF_FFFD, 1'b0}) begin
            n_bad++;
            $display("FAIL mul_result: got res=%h ovf=%b, want res=fffffffd ovf=0", result, overflow);
        end
        step(1);
    endtask

    task automatic test_backpressure;
        int w;
        out_ready = 1'b0;
        send(4'h5, 32'h0000_F0F0, 32'h0000_0FF0, w);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({out_valid, in_ready, result} !== {1'b1, 1'b0, 32'h0000_FF00}) begin
                n_bad++;
                $display("FAIL hold_cycle%0d: got v=%b rdy=%b res=%h, want v=1 rdy=0 res=0000ff00",
                         i, out_valid, in_ready, result);
            end
            step(1);
        end
        out_ready = 1'b1;
        send(4'h4, 32'd1, 32'd2, w);
        n_cmp++;
        if (w != 0) begin
            n_bad++;
            $display("FAIL handoff_wait: got %0d stall cycles want 0", w);
        end
        n_cmp++;
        if ({out_valid, result} !== {1'b1, 32'd3}) begin
            n_bad++;
            $display("FAIL handoff_result: got v=%b res=%h, want v=1 res=00000003", out_valid, result);
        end
        step(1);
    endtask

    task automatic test_illegal;
        int w;
        out_ready = 1'b1;
        send(4'hF, 32'd9, 32'd9, w);
        n_cmp++;
        if ({out_valid, result, illegal, zero, overflow} !== {1'b1, 32'd0, 1'b1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL illegal_code: got v=%b res=%h ill=%b z=%b ovf=%b, want v=1 res=0 ill=1 z=1 ovf=0",
                     out_valid, result, illegal, zero, overflow);
        end
        send(4'h6, 32'hFFFF_FFFF, 32'h1, w);
        step(1);
    endtask

    task automatic test_reset_mid_mul;
        int w;
        out_ready = 1'b1;
        send(4'h2, 32'h0000_1234, 32'h0000_5678, w);
        step(10);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        sb.delete();
        n_cmp++;
        if ({out_valid, result, in_ready} !== {1'b0, 32'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_mid_mul: got v=%b res=%h rdy=%b, want v=0 res=0 rdy=1",
                     out_valid, result, in_ready);
        end
        send(4'h0, 32'd1, 32'd1, w);
        n_cmp++;
        if ({out_valid, result} !== {1'b1, 32'd2}) begin
            n_bad++;
            $display("FAIL post_reset_add: got v=%b res=%h, want v=1 res=00000002", out_valid, result);
        end
        step(1);
    endtask

    task automatic test_back_to_back;
        logic [3:0] codes [5] = '{4'h0, 4'h1, 4'h3, 4'h4, 4'h5};
        int w;
        int stalls;
        out_ready = 1'b1;
        stalls    = 0;
        for (int i = 0; i < 10; i++) begin
            send(codes[$urandom_range(0, 4)], $urandom, $urandom, w);
            stalls += w;
        end
        n_cmp++;
        if (stalls != 0) begin
            n_bad++;
            $display("FAIL back_to_back: got %0d stall cycles want 0", stalls);
        end
        step(1);
    endtask

    task automatic test_random_mix;
        logic [3:0] codes [8] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h7, 4'hC};
        int w;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(codes[$urandom_range(0, 7)], $urandom, $urandom, w);
        end
    endtask

    task automatic test_drain;
        int cycles;
        cycles = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && cycles < 100) begin
            step(1);
            cycles++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d results never produced", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_mul();
        test_backpressure();
        test_illegal();
        test_reset_mid_mul();
        test_back_to_back();
        test_random_mix();
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute unit that consumes the 4-bit `alu_control` code produced by ALU control decode and performs the selected operation on two operands. Single-cycle ops (ADD, SUB, AND, OR, XOR) return a registered result one cycle after acceptance; MUL runs as an iterative shift-add over `DATA_W` cycles. It sits in the execute stage behind a valid/ready handshake on both the operand side and the result side, so the pipeline can stall on long operations.

## Interface
- `DATA_W`, 32, operand/result width (≥ 4)
- `clk`  in  1  clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operands and code valid
- `in_ready`  out  1  unit can accept an operation this cycle
- `alu_control`  in  4  operation code
- `op_a`  in  DATA_W  first operand
- `op_b`  in  DATA_W  second operand
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer takes result this cycle
- `result`  out  DATA_W  operation result
- `zero`  out  1  `result == 0`
- `overflow`  out  1  signed overflow (ADD/SUB only)
- `illegal`  out  1  accepted code was not a defined operation

## Operation
- Codes: 0000 ADD (a+b), 0001 SUB (a−b), 0010 MUL (low `DATA_W` bits of a·b), 0011 AND, 0100 OR, 0101 XOR; all other codes are illegal: result 0, `illegal`=1, `zero`=1, `overflow`=0, 1-cycle latency.
- Arithmetic wraps modulo 2^`DATA_W`. ADD overflow = operands same sign and result sign differs; SUB overflow = operand signs differ and result sign ≠ sign of a. `overflow`=0 for MUL, logic and illegal ops.
- States: IDLE, MUL, DONE.
  - IDLE: `in_ready`=1. On accept (`in_valid & in_ready`): MUL code → latch a (multiplicand), b (multiplier), clear accumulator and counter, go MUL; any other code → register result/flags, go DONE.
  - MUL: each cycle, if multiplier LSB=1 add multiplicand to accumulator; shift multiplicand left 1, multiplier right 1; counter+1. When counter reaches `DATA_W`−1 on this edge, write final accumulator to `result`, go DONE. Inputs ignored.
  - DONE: `out_valid`=1, `result`/flags stable. `out_ready`=0 → hold. `out_ready`=1 and no new accept → IDLE. `out_ready`=1 and `in_valid`=1 → result consumed and new op accepted on the same edge (as from IDLE).
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`). Never high in MUL.
- `zero` derived from registered `result`; all outputs registered except `in_ready`.

## Timing
- Reset: state IDLE; `out_valid`=0, `result`=0, `zero`=0, `overflow`=0, `illegal`=0, accumulator and counter 0; `in_ready`=1 in the cycle after reset deasserts.
- Reset mid-MUL or in DONE: operation discarded, no result emitted, outputs to reset values on that edge.
- Single-cycle op accepted at edge E0 → `out_valid`=1 from E0 until the edge where `out_ready`=1.
- MUL accepted at E0 → `out_valid`=1 after edge E`DATA_W` (latency `DATA_W` cycles).
- Back-to-back single-cycle ops with `out_ready` tied high: one result per cycle.
- Inputs sampled only on the accept edge; changing `op_a`/`op_b`/`alu_control` afterwards has no effect.

## Test plan
- Reset, then ADD a=5, b=7, `out_ready`=1 → next cycle `out_valid`=1, `result`=12, `zero`=0, `overflow`=0; following cycle `out_valid`=0.
- ADD a=0x7FFFFFFF, b=1 → `result`=0x80000000, `overflow`=1; SUB a=3, b=3 → `result`=0, `zero`=1, `overflow`=0.
- MUL a=0xFFFFFFFF, b=3 → `in_ready`=0 for 32 cycles, `out_valid` rises exactly 32 cycles after accept, `result`=0xFFFFFFFD, `overflow`=0.
- `out_ready`=0 for 5 cycles after XOR a=0xF0F0, b=0x0FF0 → `result`=0xFF00 held stable with `out_valid`=1 and `in_ready`=0; raise `out_ready` with `in_valid`=1 (OR a=1,b=2) → same-edge handoff, next `result`=3.
- Illegal code 1111, a=9, b=9 → `result`=0, `illegal`=1, `zero`=1, 1-cycle latency.
- Assert `reset` 10 cycles into a MUL → next cycle `out_valid`=0, `result`=0, `in_ready`=1; new ADD 1+1 → `result`=2.
